// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : M-stage data-memory bus plus console TX stream and debug counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic [31:0] cycle_count;

    modport master (
        output MemWriteM, ALUOutM, WriteDataM, tx_ready,
        input  ReadDataM, tx_valid, tx_data, cycle_count
    );

    modport slave (
        input  MemWriteM, ALUOutM, WriteDataM, tx_ready,
        output ReadDataM, tx_valid, tx_data, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data RAM with an MMIO window (console TX FIFO, cycle counter).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    dmem_responder_if.slave bus
);
    localparam int         AW         = $clog2(DEPTH_WORDS);
    localparam int         PW         = $clog2(FIFO_DEPTH);
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;

    logic [31:0] ram_q  [DEPTH_WORDS];
    logic [31:0] fifo_q [FIFO_DEPTH];
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic        overflow_q, overflow_d;
    logic [31:0] cycle_q, cycle_d;

    logic        mmio_sel;
    logic [1:0]  mmio_off;
    logic [AW-1:0] ram_idx;
    logic        empty, full, pop, push, tx_write, ram_we;
    logic        status_clr, cycle_load;
    logic [31:0] read_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.ALUOutM[1:0];

    always_comb begin
        mmio_sel   = (bus.ALUOutM[31:4] == MMIO_BASE[31:4]);
        mmio_off   = bus.ALUOutM[3:2];
        ram_idx    = bus.ALUOutM[AW+1:2];
        empty      = (rd_ptr_q == wr_ptr_q);
        full       = (rd_ptr_q[PW] != wr_ptr_q[PW]) &&
                     (rd_ptr_q[PW-1:0] == wr_ptr_q[PW-1:0]);
        pop        = !empty && bus.tx_ready;
        tx_write   = bus.MemWriteM && mmio_sel && (mmio_off == OFF_TXDATA);
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push       = tx_write && (!full || pop);
        ram_we     = bus.MemWriteM && !mmio_sel;
        status_clr = bus.MemWriteM && mmio_sel && (mmio_off == OFF_STATUS) &&
                     bus.WriteDataM[2];
        cycle_load = bus.MemWriteM && mmio_sel && (mmio_off == OFF_CYCLE);

        rd_ptr_d   = rd_ptr_q + {{PW{1'b0}}, pop};
        wr_ptr_d   = wr_ptr_q + {{PW{1'b0}}, push};

        overflow_d = overflow_q;
        if (status_clr)
            overflow_d = 1'b0;
        if (tx_write && full && !pop)
            overflow_d = 1'b1;

        cycle_d = cycle_load ? bus.WriteDataM : cycle_q + 32'd1;
    end

    always_comb begin
        read_data = '0;
        if (mmio_sel) begin
            case (mmio_off)
                OFF_TXDATA: read_data = empty ? 32'd0 : fifo_q[rd_ptr_q[PW-1:0]];
                OFF_STATUS: read_data = {29'd0, overflow_q, full, empty};
                OFF_CYCLE:  read_data = cycle_q;
                default:    read_data = '0;
            endcase
        end else begin
            read_data = ram_q[ram_idx];
        end
    end

    assign bus.ReadDataM   = read_data;
    assign bus.tx_valid    = !empty;
    assign bus.tx_data     = fifo_q[rd_ptr_q[PW-1:0]];
    assign bus.cycle_count = cycle_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
        end
    end

    // Storage arrays carry no reset: RAM contents survive reset by design.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram_q[ram_idx] <= bus.WriteDataM;
        if (push)
            fifo_q[wr_ptr_q[PW-1:0]] <= bus.WriteDataM;
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] TXDATA = BASE;
    localparam logic [31:0] STATUS = BASE + 32'd4;
    localparam logic [31:0] CYCLE  = BASE + 32'd8;
    localparam logic [31:0] RSVD   = BASE + 32'd12;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    dmem_responder_if bus();

    dmem_responder #(
        .DEPTH_WORDS (64),
        .FIFO_DEPTH  (4),
        .MMIO_BASE   (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.MemWriteM = 1'b0;
        bus.ALUOutM   = addr;
        #1;
        chk(tag, bus.ReadDataM, exp);
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] data);
        bus.ALUOutM    = addr;
        bus.WriteDataM = data;
        bus.MemWriteM  = 1'b1;
        cyc();
        bus.MemWriteM  = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        bus.MemWriteM  = 1'b0;
        bus.ALUOutM    = '0;
        bus.WriteDataM = '0;
        bus.tx_ready   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        rd("rst_status", STATUS, 32'h1);
        rd("rst_txdata", TXDATA, 32'h0);
        rd("rst_cycle", CYCLE, 32'h0);

        // Counter: five edges after release
        @(negedge clk);
        reset = 1'b1;
        repeat (5) cyc();
        rd("cycle_after5", CYCLE, 32'd5);
        chk("cycle_count_port", bus.cycle_count, 32'd5);
        st(CYCLE, 32'hFFFF_FFFE);
        rd("cycle_load", CYCLE, 32'hFFFF_FFFE);
        cyc();
        rd("cycle_max", CYCLE, 32'hFFFF_FFFF);
        cyc();
        rd("cycle_wrap", CYCLE, 32'h0000_0000);

        // RAM
        st(32'h10, 32'hDEAD_BEEF);
        rd("ram_0x10", 32'h10, 32'hDEAD_BEEF);
        rd("ram_wrap_0x110", 32'h110, 32'hDEAD_BEEF);
        rd("ram_lowbits_0x13", 32'h13, 32'hDEAD_BEEF);
        st(32'h20, 32'h1111_1111);
        bus.ALUOutM    = 32'h20;
        bus.WriteDataM = 32'h2222_2222;
        bus.MemWriteM  = 1'b1;
        #1;
        chk("ram_same_cycle_old", bus.ReadDataM, 32'h1111_1111);
        cyc();
        bus.MemWriteM = 1'b0;
        rd("ram_next_cycle_new", 32'h20, 32'h2222_2222);
        rd("ram_0x10_intact", 32'h10, 32'hDEAD_BEEF);

        // FIFO fill with overflow
        bus.tx_ready = 1'b0;
        st(TXDATA, 32'd1);
        chk("push_latency_valid", {31'd0, bus.tx_valid}, 32'd1);
        chk("push_latency_data", bus.tx_data, 32'd1);
        st(TXDATA, 32'd2);
        st(TXDATA, 32'd3);
        st(TXDATA, 32'd4);
        rd("fill_status_full", STATUS, 32'h2);
        chk("fill_head", bus.tx_data, 32'd1);
        st(TXDATA, 32'd5);
        rd("ovf_status", STATUS, 32'h6);
        rd("ovf_txdata_read", TXDATA, 32'd1);
        chk("stall_head_stable", bus.tx_data, 32'd1);

        // Drain
        bus.tx_ready = 1'b1;
        chk("drain_0", bus.tx_data, 32'd1);
        cyc();
        chk("drain_1", bus.tx_data, 32'd2);
        cyc();
        chk("drain_2", bus.tx_data, 32'd3);
        cyc();
        chk("drain_3", bus.tx_data, 32'd4);
        cyc();
        chk("drain_empty_valid", {31'd0, bus.tx_valid}, 32'd0);
        bus.tx_ready = 1'b0;
        rd("drain_status", STATUS, 32'h5);
        rd("empty_txdata_read", TXDATA, 32'h0);

        // Overflow clear and reserved register
        st(STATUS, 32'h4);
        rd("ovf_clear", STATUS, 32'h1);
        st(RSVD, 32'hFFFF_FFFF);
        rd("reserved_read", RSVD, 32'h0);
        rd("reserved_status", STATUS, 32'h1);

        // Push and pop on full
        st(TXDATA, 32'd10);
        st(TXDATA, 32'd11);
        st(TXDATA, 32'd12);
        st(TXDATA, 32'd13);
        rd("pp_full_status", STATUS, 32'h2);
        bus.tx_ready = 1'b1;
        st(TXDATA, 32'd14);
        chk("pp_head", bus.tx_data, 32'd11);
        rd("pp_status_no_ovf", STATUS, 32'h2);
        cyc();
        chk("pp_drain_12", bus.tx_data, 32'd12);
        cyc();
        chk("pp_drain_13", bus.tx_data, 32'd13);
        cyc();
        chk("pp_drain_14", bus.tx_data, 32'd14);
        cyc();
        chk("pp_empty", {31'd0, bus.tx_valid}, 32'd0);
        bus.tx_ready = 1'b0;

        // Async reset mid-stream
        st(TXDATA, 32'd20);
        st(TXDATA, 32'd21);
        chk("pre_reset_valid", {31'd0, bus.tx_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus.tx_valid}, 32'd0);
        rd("async_rst_status", STATUS, 32'h1);
        rd("async_rst_cycle", CYCLE, 32'h0);
        rd("async_rst_ram", 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        rd("post_rst_cycle", CYCLE, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
